b10_trace_capture: RTL and testbench

//  Downstream response recorder for the b10 voting-system core. Samples the core outputs
//  {cts, ctr, v_out} every clock while enabled. Stores only change events, each as
//  {timestamp, sample}, in an internal FIFO. A valid/ready port drains the FIFO, so a

---
 rtl/b10_trace_pkg.sv | 24 ++
 rtl/b10_trace_capture_if.sv | 11 +
 rtl/trace_fifo.sv | 74 +++++++
 rtl/b10_trace_capture.sv | 115 +++++++++++
 tb/tb_b10_trace_capture.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/b10_trace_pkg.sv
// Shared definitions for the b10 response trace recorder: sample width,
// FSM encodings and the sample packing used by both the recorder and its bench.
package b10_trace_pkg;

    localparam int SAMPLE_W = 6;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_ARM  = 2'd1;
    localparam logic [1:0] STATE_RUN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = STATE_IDLE,
        S_ARM  = STATE_ARM,
        S_RUN  = STATE_RUN
    } state_e;

    // Sample layout, MSB first: {cts, ctr, v_out[3:0]}
    function automatic logic [SAMPLE_W-1:0] pack_sample(input logic       cts,
                                                        input logic       ctr,
                                                        input logic [3:0] v_out);
        return {cts, ctr, v_out};
    endfunction

endpackage

// File: rtl/b10_trace_capture_if.sv
// Drain port of the trace recorder: valid/ready with the head entry as data.
interface b10_trace_capture_if #(
    parameter int W = 22
);
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with first-word-fall-through head read straight from the
// storage flops. A pop on full makes room for a push in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop, empty;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign valid = !empty;
    assign count = count_q;
    // Empty FIFO presents zero rather than a stale slot
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer/count update; clear overrides any push or pop
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            do_pop   = 1'b0;
            do_push  = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since dout is masked while empty
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/b10_trace_capture.sv
// Response recorder for the b10 core: timestamps changes of {cts, ctr, v_out}
// while enabled and queues them for a valid/ready reader.
module b10_trace_capture
    import b10_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int DATA_W = SAMPLE_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   cts,
    input  logic                   ctr,
    input  logic [3:0]             v_out,
    b10_trace_capture_if.master    rd,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             drops
);
    localparam int ENTRY_W = TS_W + DATA_W;

    state_e              state_q, state_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [DATA_W-1:0]   prev_q, prev_d, sample;
    logic                overflow_q, overflow_d;
    logic [7:0]          drops_q, drops_d;
    logic                push, drop, fifo_full, fifo_valid;
    logic [ENTRY_W-1:0]  push_data, fifo_dout;

    assign sample = pack_sample(cts, ctr, v_out);

    // FSM, timestamp and change detector; arm forces an entry at ts=0
    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        prev_d    = prev_q;
        push      = 1'b0;
        push_data = {ts_q, sample};
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_ARM;
                    ts_d      = '0;
                    prev_d    = sample;
                    push      = 1'b1;
                    push_data = {{TS_W{1'b0}}, sample};
                end
            end
            S_ARM, S_RUN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_RUN;
                    ts_d      = (ts_q == '1) ? ts_q : ts_q + 1'b1;
                    prev_d    = sample;
                    push      = (sample != prev_q);
                    push_data = {ts_d, sample};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drop accounting: a push into a full FIFO survives only if a pop frees a slot
    always_comb begin
        drop       = push && fifo_full && !rd.rd_ready;
        overflow_d = overflow_q;
        drops_d    = drops_q;
        if (clear) begin
            overflow_d = 1'b0;
            drops_d    = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drops_q != 8'hFF) drops_d = drops_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
            drops_q    <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    trace_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .din   (push_data),
        .pop   (rd.rd_ready),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .full  (fifo_full),
        .count (count)
    );

    assign rd.rd_valid = fifo_valid;
    assign rd.rd_data  = fifo_dout;
    assign overflow    = overflow_q;
    assign drops       = drops_q;

endmodule

// File: tb/tb_b10_trace_capture.sv
// Directed bench for b10_trace_capture: vector table for the basic change
// recording, hand sequences for overflow, full push+pop, re-arm and reset.
module tb_b10_trace_capture;
    import b10_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int TS_W  = 16;
    localparam int EW    = TS_W + SAMPLE_W;

    logic       clock = 1'b0;
    logic       reset, enable, clear, cts, ctr;
    logic [3:0] v_out;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] drops;

    b10_trace_capture_if #(.W(EW)) rd_if ();

    b10_trace_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
        .cts      (cts),
        .ctr      (ctr),
        .v_out    (v_out),
        .rd       (rd_if),
        .count    (count),
        .overflow (overflow),
        .drops    (drops)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       en;
        logic       cts;
        logic       ctr;
        logic [3:0] v;
        logic       rdy;
        logic       exp_valid;
        logic [15:0] exp_ts;
        logic [5:0] exp_s;
        logic [4:0] exp_count;
    } vec_t;

    vec_t tbl [11];
    logic [31:0] exp5 [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] ent(input logic [15:0] ts, input logic [5:0] s);
        return {10'd0, ts, s};
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0;
        cts = 1'b0; ctr = 1'b0; v_out = 4'd0; rd_if.rd_ready = 1'b0;
        tick(); tick();
        check("rst_valid",    32'(rd_if.rd_valid), 32'd0);
        check("rst_data",     32'(rd_if.rd_data),  32'd0);
        check("rst_count",    32'(count),          32'd0);
        check("rst_overflow", 32'(overflow),       32'd0);
        check("rst_drops",    32'(drops),          32'd0);
        reset = 1'b0;

        // T1: constant sample -> single forced entry
        enable = 1'b1; cts = 1'b1; ctr = 1'b0; v_out = 4'h5;
        tick();
        check("t1_valid_n1", 32'(rd_if.rd_valid), 32'd1);
        check("t1_data_n1",  32'(rd_if.rd_data),  ent(16'd0, 6'h25));
        repeat (9) tick();
        check("t1_count",    32'(count),          32'd1);
        check("t1_data",     32'(rd_if.rd_data),  ent(16'd0, 6'h25));
        enable = 1'b0; rd_if.rd_ready = 1'b1;
        tick();
        check("t1_drained",  32'(count),          32'd0);

        // T2: changes at cycles 4 and 9 with a reader always ready
        //         en cts ctr v     rdy vld ts     s      cnt
        tbl[0]  = '{1, 0, 1, 4'd0, 1, 1, 16'd0, 6'h10, 5'd1};
        tbl[1]  = '{1, 0, 1, 4'd0, 1, 0, 16'd0, 6'h00, 5'd0};
        tbl[2]  = '{1, 0, 1, 4'd0, 1, 0, 16'd0, 6'h00, 5'd0};
        tbl[3]  = '{1, 0, 1, 4'd0, 1, 0, 16'd0, 6'h00, 5'd0};
        tbl[4]  = '{1, 0, 1, 4'd1, 1, 1, 16'd4, 6'h11, 5'd1};
        tbl[5]  = '{1, 0, 1, 4'd1, 1, 0, 16'd0, 6'h00, 5'd0};
        tbl[6]  = '{1, 0, 1, 4'd1, 1, 0, 16'd0, 6'h00, 5'd0};
        tbl[7]  = '{1, 0, 1, 4'd1, 1, 0, 16'd0, 6'h00, 5'd0};
        tbl[8]  = '{1, 0, 1, 4'd1, 1, 0, 16'd0, 6'h00, 5'd0};
        tbl[9]  = '{1, 0, 1, 4'd3, 1, 1, 16'd9, 6'h13, 5'd1};
        tbl[10] = '{1, 0, 1, 4'd3, 1, 0, 16'd0, 6'h00, 5'd0};
        for (int i = 0; i < 11; i++) begin
            enable = tbl[i].en; cts = tbl[i].cts; ctr = tbl[i].ctr;
            v_out = tbl[i].v; rd_if.rd_ready = tbl[i].rdy;
            tick();
            check($sformatf("t2_valid[%0d]", i), 32'(rd_if.rd_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                check($sformatf("t2_data[%0d]", i), 32'(rd_if.rd_data),
                      ent(tbl[i].exp_ts, tbl[i].exp_s));
            check($sformatf("t2_count[%0d]", i), 32'(count), 32'(tbl[i].exp_count));
        end

        // T3: re-arm and toggle cts for DEPTH+5 cycles with no reader
        enable = 1'b0; rd_if.rd_ready = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t3_clear_count", 32'(count), 32'd0);
        for (int i = 0; i < DEPTH + 5; i++) begin
            enable = 1'b1; cts = i[0]; ctr = 1'b0; v_out = 4'h5;
            tick();
        end
        check("t3_count",    32'(count),          32'd16);
        check("t3_overflow", 32'(overflow),       32'd1);
        check("t3_drops",    32'(drops),          32'd5);
        check("t3_valid",    32'(rd_if.rd_valid), 32'd1);
        check("t3_head",     32'(rd_if.rd_data),  ent(16'd0, 6'h05));

        // T4: full FIFO, pop and change in the same cycle
        cts = 1'b1; rd_if.rd_ready = 1'b1;
        tick();
        check("t4_count", 32'(count),         32'd16);
        check("t4_drops", 32'(drops),         32'd5);
        check("t4_head",  32'(rd_if.rd_data), ent(16'd1, 6'h25));
        rd_if.rd_ready = 1'b0;
        tick();
        check("t4_hold_count", 32'(count), 32'd16);
        check("t4_hold_drops", 32'(drops), 32'd5);
        // Drain: ts 1..15 alternate cts, then the ts=21 entry pushed during the pop
        enable = 1'b0; rd_if.rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            automatic int ts = (k < 15) ? k + 1 : 21;
            check($sformatf("t4_drain[%0d]", k), 32'(rd_if.rd_data),
                  ent(16'(ts), (ts % 2 == 1) ? 6'h25 : 6'h05));
            tick();
        end
        check("t4_empty_count", 32'(count),          32'd0);
        check("t4_empty_valid", 32'(rd_if.rd_valid), 32'd0);
        check("t4_sticky_ovf",  32'(overflow),       32'd1);
        rd_if.rd_ready = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_drops",    32'(drops),    32'd0);

        // T5: disable for 3 cycles with changing samples, then re-arm
        enable = 1'b1; cts = 1'b0; ctr = 1'b0; v_out = 4'd1;
        tick(); tick();
        v_out = 4'd2; tick();
        enable = 1'b0;
        v_out = 4'd3; tick();
        v_out = 4'd4; tick();
        v_out = 4'd5; tick();
        check("t5_idle_count", 32'(count), 32'd2);
        enable = 1'b1; v_out = 4'd6; tick();
        v_out = 4'd7; tick();
        check("t5_count", 32'(count), 32'd4);
        exp5[0] = ent(16'd0, 6'h01);
        exp5[1] = ent(16'd2, 6'h02);
        exp5[2] = ent(16'd0, 6'h06);
        exp5[3] = ent(16'd1, 6'h07);
        enable = 1'b0; rd_if.rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5_drain[%0d]", k), 32'(rd_if.rd_data), exp5[k]);
            tick();
        end
        rd_if.rd_ready = 1'b0;

        // T6: reset mid-trace with 5 entries queued at ts=40
        enable = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            v_out = 4'(k / 10);
            tick();
        end
        check("t6_pre_count", 32'(count), 32'd5);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_valid",    32'(rd_if.rd_valid), 32'd0);
        check("t6_rst_count",    32'(count),          32'd0);
        check("t6_rst_overflow", 32'(overflow),       32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        tick();
        check("t6_rearm_valid", 32'(rd_if.rd_valid), 32'd1);
        check("t6_rearm_data",  32'(rd_if.rd_data),  ent(16'd0, 6'h04));
        check("t6_rearm_count", 32'(count),          32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
